// File: rtl/connect4_pkg.sv
`default_nettype none
// ============================================================================
// Module : connect4_pkg
// Brief  : Shared Connect4 types and constants (cursor states, board size).
// Rev    : 1.0
// ============================================================================
package connect4_pkg;
    localparam int NUM_COLS_DEFAULT = 7;
    localparam int NUM_ROWS         = 6;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        HOLD_L    = 2'd1,
        HOLD_R    = 2'd2,
        DROP_WAIT = 2'd3
    } cursor_state_t;
endpackage
`default_nettype wire

// File: rtl/col_search.sv
`default_nettype none
// ============================================================================
// Module : col_search
// Brief  : Combinational finder for the next non-full column from a start
//          column in one direction, optionally wrapping around the board.
// Rev    : 1.0
// ============================================================================
module col_search #(
    parameter int NUM_COLS = 7,
    parameter int COL_W    = $clog2(NUM_COLS)
) (
    input  logic [COL_W-1:0]    i_start,
    input  logic                i_dir_right,
    input  logic                i_wrap,
    input  logic [NUM_COLS-1:0] i_col_full,
    output logic                o_found,
    output logic [COL_W-1:0]    o_col
);
    always_comb begin
        int cand;
        o_found = 1'b0;
        o_col   = i_start;
        cand    = 0;
        // Nearest candidate first; the start column itself is never a result
        for (int k = 1; k < NUM_COLS; k++) begin
            cand = i_dir_right ? (int'(i_start) + k) : (int'(i_start) - k);
            if (i_wrap) begin
                if (cand >= NUM_COLS) cand = cand - NUM_COLS;
                if (cand < 0)         cand = cand + NUM_COLS;
            end
            if (!o_found && (cand >= 0) && (cand < NUM_COLS)) begin
                if (!i_col_full[cand[COL_W-1:0]]) begin
                    o_found = 1'b1;
                    o_col   = cand[COL_W-1:0];
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/column_cursor_fsm.sv
`default_nettype none
// ============================================================================
// Module : column_cursor_fsm
// Brief  : Connect4 column cursor with skip-full, re-home, auto-repeat and a
//          valid/ready drop request towards the board logic.
// Rev    : 1.0
// ============================================================================
module column_cursor_fsm
    import connect4_pkg::*;
#(
    parameter int NUM_COLS  = NUM_COLS_DEFAULT,
    parameter int COL_W     = $clog2(NUM_COLS),
    parameter bit WRAP      = 1'b0,
    parameter int RPT_DELAY = 50_000_000,
    parameter int RPT_RATE  = 10_000_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                L,
    input  logic                R,
    input  logic                drop,
    input  logic [NUM_COLS-1:0] col_full,
    output logic [COL_W-1:0]    colval,
    output logic                cursor_valid,
    output logic                drop_valid,
    output logic [COL_W-1:0]    drop_col,
    input  logic                drop_ready
);
    localparam logic [31:0] c_dly_last  = 32'(RPT_DELAY - 1);
    localparam logic [31:0] c_rate_last = 32'(RPT_RATE - 1);

    cursor_state_t    r_state, w_state_nxt;
    logic [COL_W-1:0] r_col, w_col_nxt;
    logic [COL_W-1:0] r_dcol, w_dcol_nxt;
    logic [31:0]      r_cnt, w_cnt_nxt;
    logic             r_rpt, w_rpt_nxt;
    logic             r_dv, w_dv_nxt;
    logic             r_l_q, r_r_q, r_d_q;

    logic             w_l_rise, w_r_rise, w_d_rise;
    logic             w_cursor_valid, w_need_rehome, w_held, w_tick;
    logic             w_mv_right, w_mv_dir, w_mv_wrap, w_mv_found, w_rf_found;
    logic [COL_W-1:0] w_mv_col, w_rf_col;

    assign w_l_rise       = L & ~r_l_q;
    assign w_r_rise       = R & ~r_r_q;
    assign w_d_rise       = drop & ~r_d_q;
    assign w_cursor_valid = ~&col_full;
    assign w_need_rehome  = col_full[r_col];
    assign w_held         = (r_state == HOLD_L) ? (L & ~R) : (R & ~L);
    assign w_tick         = r_rpt ? (r_cnt == c_rate_last) : (r_cnt == c_dly_last);
    assign w_mv_right     = (r_state == HOLD_R) | ((r_state == IDLE) & R);

    // Moves are suppressed while re-homing, so the move finder doubles as the
    // leftward half of the re-home search.
    assign w_mv_dir  = w_need_rehome ? 1'b0 : w_mv_right;
    assign w_mv_wrap = w_need_rehome ? 1'b0 : WRAP;

    col_search #(.NUM_COLS(NUM_COLS), .COL_W(COL_W)) u_move_search (
        .i_start     (r_col),
        .i_dir_right (w_mv_dir),
        .i_wrap      (w_mv_wrap),
        .i_col_full  (col_full),
        .o_found     (w_mv_found),
        .o_col       (w_mv_col)
    );

    col_search #(.NUM_COLS(NUM_COLS), .COL_W(COL_W)) u_rehome_search (
        .i_start     (r_col),
        .i_dir_right (1'b1),
        .i_wrap      (1'b0),
        .i_col_full  (col_full),
        .o_found     (w_rf_found),
        .o_col       (w_rf_col)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col;
        w_cnt_nxt   = r_cnt;
        w_rpt_nxt   = r_rpt;
        w_dv_nxt    = r_dv;
        w_dcol_nxt  = r_dcol;
        case (r_state)
            IDLE: begin
                if (w_need_rehome) begin
                    if (w_rf_found)      w_col_nxt = w_rf_col;
                    else if (w_mv_found) w_col_nxt = w_mv_col;
                end else if (w_l_rise && !R) begin
                    if (w_mv_found) w_col_nxt = w_mv_col;
                    w_state_nxt = HOLD_L;
                    w_cnt_nxt   = '0;
                    w_rpt_nxt   = 1'b0;
                end else if (w_r_rise && !L) begin
                    if (w_mv_found) w_col_nxt = w_mv_col;
                    w_state_nxt = HOLD_R;
                    w_cnt_nxt   = '0;
                    w_rpt_nxt   = 1'b0;
                end else if (w_d_rise && w_cursor_valid) begin
                    w_dv_nxt    = 1'b1;
                    w_dcol_nxt  = r_col;
                    w_state_nxt = DROP_WAIT;
                end
            end
            HOLD_L, HOLD_R: begin
                if (!w_held) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                    w_rpt_nxt   = 1'b0;
                end else begin
                    if (w_tick) begin
                        w_cnt_nxt = '0;
                        w_rpt_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 32'd1;
                    end
                    if (w_need_rehome) begin
                        if (w_rf_found)      w_col_nxt = w_rf_col;
                        else if (w_mv_found) w_col_nxt = w_mv_col;
                    end else if (w_tick && w_mv_found) begin
                        w_col_nxt = w_mv_col;
                    end
                end
            end
            DROP_WAIT: begin
                if (drop_ready) begin
                    w_dv_nxt    = 1'b0;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
                w_rpt_nxt   = 1'b0;
                w_dv_nxt    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // Edge history always tracks the levels, so buttons held through
        // reset or a drop handshake never fire afterwards.
        r_l_q <= L;
        r_r_q <= R;
        r_d_q <= drop;
        if (rst || clr) begin
            r_state <= IDLE;
            r_col   <= '0;
            r_cnt   <= '0;
            r_rpt   <= 1'b0;
            r_dv    <= 1'b0;
            r_dcol  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_col   <= w_col_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rpt   <= w_rpt_nxt;
            r_dv    <= w_dv_nxt;
            r_dcol  <= w_dcol_nxt;
        end
    end

    assign colval       = r_col;
    assign cursor_valid = w_cursor_valid;
    assign drop_valid   = r_dv;
    assign drop_col     = r_dcol;
endmodule
`default_nettype wire

// File: tb/tb_column_cursor_fsm.sv
`default_nettype none
// Bench for column_cursor_fsm: saturating and wrapping instances share stimulus
// and are compared every cycle against a behavioural cursor model.
module tb_column_cursor_fsm;
    localparam int N   = 7;
    localparam int DLY = 4;
    localparam int RAT = 2;

    logic         clk = 1'b0;
    logic         rst, clr, L, R, drop, drop_ready;
    logic [N-1:0] col_full;
    logic [2:0]   colval0, colval1, dcol0, dcol1;
    logic         cv0, cv1, dv0, dv1;

    int n_chk  = 0;
    int n_fail = 0;

    // model state, index 0 = saturate instance, 1 = wrap instance
    int m_col[2], m_mode[2], m_d[2], m_dcol[2];
    bit m_dv[2];
    bit pl, pr, pd;

    always #5 clk = ~clk;

    column_cursor_fsm #(.NUM_COLS(N), .WRAP(1'b0), .RPT_DELAY(DLY), .RPT_RATE(RAT)) dut0 (
        .clk(clk), .rst(rst), .clr(clr), .L(L), .R(R), .drop(drop),
        .col_full(col_full), .colval(colval0), .cursor_valid(cv0),
        .drop_valid(dv0), .drop_col(dcol0), .drop_ready(drop_ready));

    column_cursor_fsm #(.NUM_COLS(N), .WRAP(1'b1), .RPT_DELAY(DLY), .RPT_RATE(RAT)) dut1 (
        .clk(clk), .rst(rst), .clr(clr), .L(L), .R(R), .drop(drop),
        .col_full(col_full), .colval(colval1), .cursor_valid(cv1),
        .drop_valid(dv1), .drop_col(dcol1), .drop_ready(drop_ready));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int srch(input int c, input bit right, input bit wrap, input logic [N-1:0] f);
        int r;
        r = -1;
        if (right) begin
            for (int k = c + 1; k < N; k++) if (r < 0 && !f[k]) r = k;
            if (wrap) for (int k = 0; k < c; k++) if (r < 0 && !f[k]) r = k;
        end else begin
            for (int k = c - 1; k >= 0; k--) if (r < 0 && !f[k]) r = k;
            if (wrap) for (int k = N - 1; k > c; k--) if (r < 0 && !f[k]) r = k;
        end
        return r;
    endfunction

    function automatic int rehome(input int c, input logic [N-1:0] f);
        int r;
        r = srch(c, 1'b1, 1'b0, f);
        if (r < 0) r = srch(c, 1'b0, 1'b0, f);
        return r;
    endfunction

    task automatic model_step();
        bit lr, rr, dr, held, rep, wrap;
        int t;
        lr = L && !pl;
        rr = R && !pr;
        dr = drop && !pd;
        for (int u = 0; u < 2; u++) begin
            wrap = (u == 1);
            if (rst || clr) begin
                m_col[u] = 0; m_mode[u] = 0; m_d[u] = 0; m_dv[u] = 0; m_dcol[u] = 0;
            end else begin
                case (m_mode[u])
                    0: begin
                        if (col_full[m_col[u]]) begin
                            t = rehome(m_col[u], col_full);
                            if (t >= 0) m_col[u] = t;
                        end else if (lr && !R) begin
                            t = srch(m_col[u], 1'b0, wrap, col_full);
                            if (t >= 0) m_col[u] = t;
                            m_mode[u] = 1; m_d[u] = 0;
                        end else if (rr && !L) begin
                            t = srch(m_col[u], 1'b1, wrap, col_full);
                            if (t >= 0) m_col[u] = t;
                            m_mode[u] = 2; m_d[u] = 0;
                        end else if (dr && (col_full != {N{1'b1}})) begin
                            m_dv[u] = 1; m_dcol[u] = m_col[u]; m_mode[u] = 3;
                        end
                    end
                    1, 2: begin
                        held = (m_mode[u] == 1) ? (L && !R) : (R && !L);
                        if (!held) begin
                            m_mode[u] = 0;
                        end else begin
                            m_d[u]++;
                            rep = (m_d[u] == DLY) || (m_d[u] > DLY && ((m_d[u] - DLY) % RAT) == 0);
                            if (col_full[m_col[u]]) begin
                                t = rehome(m_col[u], col_full);
                                if (t >= 0) m_col[u] = t;
                            end else if (rep) begin
                                t = srch(m_col[u], m_mode[u] == 2, wrap, col_full);
                                if (t >= 0) m_col[u] = t;
                            end
                        end
                    end
                    default: begin
                        if (drop_ready) begin m_dv[u] = 0; m_mode[u] = 0; end
                    end
                endcase
            end
        end
        pl = L; pr = R; pd = drop;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("colval_sat", colval0, m_col[0]);
        chk("colval_wrap", colval1, m_col[1]);
        chk("dvalid_sat", dv0, m_dv[0]);
        chk("dvalid_wrap", dv1, m_dv[1]);
        chk("dcol_sat", dcol0, m_dcol[0]);
        chk("dcol_wrap", dcol1, m_dcol[1]);
        chk("cvalid_sat", cv0, col_full != {N{1'b1}});
        chk("cvalid_wrap", cv1, col_full != {N{1'b1}});
    endtask

    task automatic do_reset();
        rst = 1'b1; tick(); rst = 1'b0;
    endtask

    task automatic pulse_r();
        R = 1'b1; tick(); R = 1'b0; tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hold_exp[12] = '{1, 1, 1, 1, 2, 2, 3, 3, 4, 4, 5, 5};
        rst = 1'b1; clr = 1'b0; L = 1'b0; R = 1'b0; drop = 1'b0; drop_ready = 1'b0;
        col_full = '0;
        pl = 0; pr = 0; pd = 0;
        @(negedge clk);
        tick(); tick();
        chk("reset_colval", colval0, 0);
        chk("reset_dvalid", dv0, 0);
        chk("reset_dcol", dcol0, 0);
        chk("reset_cvalid", cv0, 1);
        rst = 1'b0;

        // saturating walk right, wrap instance rolls over
        for (int k = 0; k < 8; k++) begin
            pulse_r();
            chk("r_pulse_sat", colval0, (k < 6) ? k + 1 : 6);
            chk("r_pulse_wrap", colval1, (k + 1) % 7);
        end
        do_reset();
        L = 1'b1; tick(); L = 1'b0; tick();
        chk("l_at_0_sat", colval0, 0);
        chk("l_at_0_wrap", colval1, 6);

        // skip full columns, re-home, all full
        col_full = 7'b0011100;
        do_reset();
        pulse_r();
        chk("skip_to_1", colval0, 1);
        pulse_r();
        chk("skip_to_5", colval0, 5);
        col_full = 7'b0111100;
        tick();
        chk("rehome_6", colval0, 6);
        col_full = 7'h7F;
        tick();
        chk("all_full_cvalid", cv0, 0);
        drop = 1'b1; tick(); drop = 1'b0; tick();
        chk("all_full_nodrop", dv0, 0);
        chk("all_full_hold", colval0, 6);

        // auto-repeat
        col_full = '0;
        do_reset();
        R = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("hold_r", colval0, hold_exp[i]);
        end
        R = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("release_r", colval0, 5);

        // drop handshake
        do_reset();
        pulse_r(); pulse_r(); pulse_r();
        drop = 1'b1; tick(); drop = 1'b0;
        for (int i = 0; i < 5; i++) begin
            L = (i % 2 == 0);
            tick();
            chk("drop_wait_dv", dv0, 1);
            chk("drop_wait_col", dcol0, 3);
            chk("drop_wait_frozen", colval0, 3);
        end
        L = 1'b0;
        drop_ready = 1'b1; tick(); drop_ready = 1'b0;
        chk("drop_accept", dv0, 0);
        tick();

        // reset during DROP_WAIT and HOLD_R
        drop = 1'b1; tick(); drop = 1'b0;
        chk("drop_again", dv0, 1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst_drop_col", colval0, 0);
        chk("rst_drop_dv", dv0, 0);
        R = 1'b1; tick(); tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst_hold_col", colval0, 0);
        tick();
        chk("held_thru_rst", colval0, 0);
        R = 1'b0; tick();

        // simultaneous L and R
        pulse_r(); pulse_r(); pulse_r();
        L = 1'b1; R = 1'b1; tick();
        chk("lr_same_cycle", colval0, 3);
        tick(); tick(); tick(); tick(); tick();
        chk("lr_held", colval0, 3);
        L = 1'b0; R = 1'b0; tick();

        // randomized phase
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(5) == 0) L = ~L;
            if ($urandom_range(5) == 0) R = ~R;
            if ($urandom_range(7) == 0) drop = ~drop;
            drop_ready = ($urandom_range(2) == 0);
            if ($urandom_range(49) == 0)
                col_full = ($urandom_range(9) == 0) ? 7'h7F : 7'($urandom() & $urandom());
            clr = ($urandom_range(299) == 0);
            rst = ($urandom_range(499) == 0);
            tick();
        end
        clr = 1'b0; rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/column_cursor_fsm.md
Name: column_cursor_fsm

Overview:
- Parametrised successor to the Connect4 column selector.
- Moves a column cursor across NUM_COLS columns from debounced left/right buttons, with selectable wrap or saturate mode and hold-to-auto-repeat.
- Skips columns flagged full; the cursor re-homes when its own column fills.
- Issues a drop request to the board/placement logic through a valid/ready handshake.
- Sits between the button debouncers and the board-update FSM; cursor output also drives the VGA column highlight.

Parameters:
- NUM_COLS, 7, number of board columns (2..16).
- COL_W, $clog2(NUM_COLS), cursor width (derived; not overridden).
- WRAP, 0, 0 = saturate at column 0 / NUM_COLS-1; 1 = wrap around.
- RPT_DELAY, 50_000_000, clk cycles a direction button must be held before the first auto-repeat.
- RPT_RATE, 10_000_000, clk cycles between subsequent auto-repeats.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- clr  in  1  synchronous active-high game clear; same effect as rst on this block.
- L  in  1  debounced left button level.
- R  in  1  debounced right button level.
- drop  in  1  debounced drop button level.
- col_full  in  NUM_COLS  bit i = 1 means column i is full.
- colval  out  COL_W  current cursor column.
- cursor_valid  out  1  0 when every column is full.
- drop_valid  out  1  drop request pending.
- drop_col  out  COL_W  column of the pending drop; stable while drop_valid = 1.
- drop_ready  in  1  board logic accepts the drop.

Behaviour:
- Reset/clear
  - colval = 0, drop_valid = 0, drop_col = 0, repeat counter = 0, state = IDLE.
  - Button edge registers are loaded with the current L/R/drop levels, so buttons already held at reset do not fire.
  - cursor_valid = |~col_full (combinational).
- Move search
  - Right from c: first non-full column among c+1..NUM_COLS-1. If WRAP = 1, continue with 0..c-1.
  - Left: mirror image of right.
  - If no column is found, colval is unchanged.
  - A move never lands on a full column. colval never exceeds NUM_COLS-1.
- Edges and latency
  - Rising edge of L or R → one move. colval updates on the cycle after the edge is sampled (1-cycle latency).
  - L and R both high, or rising on the same cycle → no move, no repeat.
- States
  - IDLE
    - L rise alone → move left, go to HOLD_L, counter = 0.
    - R rise alone → move right, go to HOLD_R, counter = 0.
    - drop rise with cursor_valid = 1 → drop_valid = 1, drop_col = colval, go to DROP_WAIT.
    - drop rise when cursor_valid = 0 is ignored.
  - HOLD_L / HOLD_R
    - Counter increments each cycle.
    - At RPT_DELAY-1: extra move, counter = 0, repeat phase begins.
    - Each further RPT_RATE-1: another move.
    - Button release, or the opposite button asserted → IDLE, no move.
    - drop is ignored in these states.
  - DROP_WAIT
    - L, R and drop are ignored; colval is frozen.
    - drop_valid and drop_col are held until the cycle where drop_valid && drop_ready.
    - On the following cycle: drop_valid = 0, return to IDLE.
- Re-home
  - In IDLE or HOLD_*, if col_full[colval] = 1: colval moves on the next cycle to the nearest non-full column, searching right first, then left, with no wrap.
  - Re-home takes priority over a same-cycle button move.
  - If all columns are full: colval holds and cursor_valid = 0.
- Illegal states → IDLE.

Decomposition:
- Shared package connect4_pkg:
  - typedef enum of the cursor states {IDLE, HOLD_L, HOLD_R, DROP_WAIT}.
  - NUM_COLS_DEFAULT = 7 and NUM_ROWS = 6, shared with the board FSM.
- Sub-module col_search: combinational next-free-column finder.
  - Inputs: start column, direction, wrap, col_full.
  - Outputs: found, column.
  - Instantiated twice: once for the move, once for the re-home.

Test Plan:
- Reset, NUM_COLS = 7, WRAP = 0, col_full = 0: 8 R pulses → colval 1,2,3,4,5,6,6,6; L at 0 → stays 0.
- WRAP = 1: from colval = 6, R pulse → 0; from 0, L pulse → 6.
- col_full = 7'b0011100, colval = 1, R pulse → 5. Then set col_full[5] → colval re-homes to 6 in one cycle. col_full = 7'h7F → cursor_valid = 0, drop ignored.
- RPT_DELAY = 4, RPT_RATE = 2, hold R for 12 cycles from 0 → colval steps to 1 immediately, then 2, 3, 4, 5 at the delay/rate points; R release → no further moves.
- drop pulse at colval = 3 with drop_ready = 0 for 5 cycles:
  - drop_valid = 1 and drop_col = 3 held throughout; L pulses have no effect.
  - drop_ready = 1 for one cycle → drop_valid = 0 the next cycle.
- rst asserted mid-DROP_WAIT and mid-HOLD_R → next cycle colval = 0, drop_valid = 0, state IDLE. L and R both rising on the same cycle → colval unchanged.
